// File: rtl/edge_path_sched_if.sv
// ----------------------------------------------------------------------------
// edge_path_sched_if
//   Bundles the trigger/data inputs and the scheduled-path outputs of
//   edge_path_sched.
//   master : drives trig/data, observes the path outputs (source side / bench)
//   slave  : the scheduler itself
//   Signals:
//     trig        edge source of the modelled path
//     data        value source for q
//     q           scheduled path output
//     busy        a transition is pending
//     pend_val    value q takes when the pending transition completes (=q idle)
//     pend_neg    pending event came from a negedge (0 when idle)
//     cancel_cnt  saturating count of cancelled events
// ----------------------------------------------------------------------------
interface edge_path_sched_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             trig;
  logic             data;
  logic             q;
  logic             busy;
  logic             pend_val;
  logic             pend_neg;
  logic [CNT_W-1:0] cancel_cnt;

  modport master (
    output trig,
    output data,
    input  q,
    input  busy,
    input  pend_val,
    input  pend_neg,
    input  cancel_cnt
  );

  modport slave (
    input  trig,
    input  data,
    output q,
    output busy,
    output pend_val,
    output pend_neg,
    output cancel_cnt
  );
endinterface

// File: rtl/edge_path_sched.sv
// ----------------------------------------------------------------------------
// edge_path_sched
//   Cycle-based timing model of an edge-sensitive, state-dependent module path
//   (posedge/negedge trig => q : data). A trig edge samples data as the target
//   value; q takes that value a fixed number of clk edges later, the delay
//   depending on edge type and on whether q rises or falls. A later edge that
//   asks for the current q value cancels the pending transition (inertial).
//
//   Ports:
//     i_clk    clock, all state updates on its rising edge
//     i_rst_n  synchronous reset, active low
//     bus      edge_path_sched_if.slave (trig, data in; q, busy, pend_val,
//              pend_neg, cancel_cnt out; all outputs registered)
// ----------------------------------------------------------------------------
module edge_path_sched #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned POS_RISE = 10,
  parameter int unsigned POS_FALL = 5,
  parameter int unsigned NEG_RISE = 20,
  parameter int unsigned NEG_FALL = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  edge_path_sched_if.slave       bus
);

  // A zero delay behaves as a one-cycle delay.
  localparam logic [CNT_W-1:0] L_POS_RISE = CNT_W'((POS_RISE == 0) ? 1 : POS_RISE);
  localparam logic [CNT_W-1:0] L_POS_FALL = CNT_W'((POS_FALL == 0) ? 1 : POS_FALL);
  localparam logic [CNT_W-1:0] L_NEG_RISE = CNT_W'((NEG_RISE == 0) ? 1 : NEG_RISE);
  localparam logic [CNT_W-1:0] L_NEG_FALL = CNT_W'((NEG_FALL == 0) ? 1 : NEG_FALL);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    StArm   = 2'd0,
    StIdle  = 2'd1,
    StCount = 2'd2
  } state_e;

  state_e           r_state,      w_state_d;
  logic             r_trig_d;
  logic             r_q,          w_q_d;
  logic             r_pend_val,   w_pend_val_d;
  logic             r_pend_neg,   w_pend_neg_d;
  logic [CNT_W-1:0] r_cnt,        w_cnt_d;
  logic [CNT_W-1:0] r_cancel_cnt, w_cancel_cnt_d;

  logic             w_pos;
  logic             w_neg;
  logic             w_edge;
  logic [CNT_W-1:0] w_delay;

  // Edges are suppressed in ARM: r_trig_d holds no valid history there yet.
  assign w_pos  = (r_state != StArm) & ~r_trig_d &  bus.trig;
  assign w_neg  = (r_state != StArm) &  r_trig_d & ~bus.trig;
  assign w_edge = w_pos | w_neg;

  always_comb begin
    w_delay = L_POS_FALL;
    unique case ({w_neg, bus.data})
      2'b01:   w_delay = L_POS_RISE;
      2'b00:   w_delay = L_POS_FALL;
      2'b11:   w_delay = L_NEG_RISE;
      2'b10:   w_delay = L_NEG_FALL;
      default: w_delay = L_POS_FALL;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    w_state_d      = r_state;
    w_q_d          = r_q;
    w_pend_val_d   = r_pend_val;
    w_pend_neg_d   = r_pend_neg;
    w_cnt_d        = r_cnt;
    w_cancel_cnt_d = r_cancel_cnt;

    unique case (r_state)
      StArm: begin
        w_state_d = StIdle;
      end

      StIdle: begin
        if (w_edge && (bus.data != r_q)) begin
          // Counter ends at 0 on the cycle before q updates, so q moves D edges later.
          w_cnt_d      = w_delay - L_ONE;
          w_pend_val_d = bus.data;
          w_pend_neg_d = w_neg;
          w_state_d    = StCount;
        end
      end

      StCount: begin
        if (w_edge && (bus.data != r_pend_val)) begin
          // With a 1-bit q, target != pend_val implies target == q: cancel.
          // The new edge wins over a completion in the same cycle.
          w_state_d    = StIdle;
          w_pend_val_d = r_q;
          w_pend_neg_d = 1'b0;
          w_cnt_d      = '0;
          if (r_cancel_cnt != '1) begin
            w_cancel_cnt_d = r_cancel_cnt + L_ONE;
          end
        end else if (r_cnt == '0) begin
          w_q_d        = r_pend_val;
          w_pend_neg_d = 1'b0;
          w_state_d    = StIdle;
        end else begin
          // Includes an edge whose target matches the pending value.
          w_cnt_d = r_cnt - L_ONE;
        end
      end

      default: begin
        w_state_d = StArm;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StArm;
      r_trig_d     <= 1'b0;
      r_q          <= 1'b0;
      r_pend_val   <= 1'b0;
      r_pend_neg   <= 1'b0;
      r_cnt        <= '0;
      r_cancel_cnt <= '0;
    end else begin
      r_state      <= w_state_d;
      r_trig_d     <= bus.trig;
      r_q          <= w_q_d;
      r_pend_val   <= w_pend_val_d;
      r_pend_neg   <= w_pend_neg_d;
      r_cnt        <= w_cnt_d;
      r_cancel_cnt <= w_cancel_cnt_d;
    end
  end

  assign bus.q          = r_q;
  assign bus.busy       = (r_state == StCount);
  assign bus.pend_val   = r_pend_val;
  assign bus.pend_neg   = r_pend_neg;
  assign bus.cancel_cnt = r_cancel_cnt;

endmodule

// File: tb/tb_edge_path_sched.sv
// ----------------------------------------------------------------------------
// tb_edge_path_sched
//   Drives two schedulers (default delays, and NEG_RISE=0) with directed and
//   random stimulus. A behavioural model tracks each path as "pending value
//   due at absolute cycle N"; every negedge the outputs are compared to it.
// ----------------------------------------------------------------------------
module tb_edge_path_sched;

  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  edge_path_sched_if #(.CNT_W(CNT_W)) bus0 ();
  edge_path_sched_if #(.CNT_W(CNT_W)) bus1 ();

  edge_path_sched #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  edge_path_sched #(.CNT_W(CNT_W), .NEG_RISE(0)) dut_z (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  typedef struct {
    bit armed;
    bit prev;
    bit q;
    bit busy;
    bit pval;
    bit pneg;
    int due;
    int cnc;
  } mdl_t;

  mdl_t m0, m1;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  bit   chk_en = 1'b0;

  function automatic mdl_t step(input mdl_t m, input bit rn, input bit t, input bit d,
                                input int c, input int dpr, input int dpf,
                                input int dnr, input int dnf);
    mdl_t n;
    bit   pos, neg;
    int   dl;
    n = m;
    if (!rn) begin
      n = '{default: 0};
      return n;
    end
    if (!n.armed) begin
      n.armed = 1'b1;
      n.prev  = t;
      return n;
    end
    pos    = !n.prev && t;
    neg    = n.prev && !t;
    n.prev = t;
    if (pos || neg) begin
      if (pos) dl = d ? dpr : dpf;
      else     dl = d ? dnr : dnf;
      if (dl == 0) dl = 1;
      if (!n.busy) begin
        if (d != n.q) begin
          n.busy = 1'b1;
          n.pval = d;
          n.pneg = neg;
          n.due  = c + dl;
        end
      end else if (d != n.pval) begin
        n.busy = 1'b0;
        n.pval = n.q;
        n.pneg = 1'b0;
        if (n.cnc < CMAX) n.cnc++;
        return n;
      end
    end
    if (n.busy && c == n.due) begin
      n.q    = n.pval;
      n.busy = 1'b0;
      n.pneg = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, step the models, settle at negedge.
  task automatic tick(input bit rn, input bit t, input bit d);
    rst_n     = rn;
    bus0.trig = t;
    bus0.data = d;
    bus1.trig = t;
    bus1.data = d;
    @(posedge clk);
    cyc++;
    m0 = step(m0, rn, t, d, cyc, 10, 5, 20, 12);
    m1 = step(m1, rn, t, d, cyc, 10, 5, 0, 12);
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q",          32'(bus0.q),          32'(m0.q));
      chk("busy",       32'(bus0.busy),       32'(m0.busy));
      chk("pend_val",   32'(bus0.pend_val),   32'(m0.pval));
      chk("pend_neg",   32'(bus0.pend_neg),   32'(m0.pneg));
      chk("cancel_cnt", 32'(bus0.cancel_cnt), 32'(m0.cnc));
      chk("z_q",          32'(bus1.q),          32'(m1.q));
      chk("z_busy",       32'(bus1.busy),       32'(m1.busy));
      chk("z_pend_val",   32'(bus1.pend_val),   32'(m1.pval));
      chk("z_pend_neg",   32'(bus1.pend_neg),   32'(m1.pneg));
      chk("z_cancel_cnt", 32'(bus1.cancel_cnt), 32'(m1.cnc));
    end
  end

  initial begin
    bus0.trig = 1'b0; bus0.data = 1'b0;
    bus1.trig = 1'b0; bus1.data = 1'b0;
    m0 = '{default: 0};
    m1 = '{default: 0};

    // Reset state
    repeat (3) tick(0, 0, 0);
    chk("rst_q", 32'(bus0.q), 0);
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_pend_val", 32'(bus0.pend_val), 0);
    chk("rst_pend_neg", 32'(bus0.pend_neg), 0);
    chk("rst_cancel_cnt", 32'(bus0.cancel_cnt), 0);
    tick(1, 0, 0);
    repeat (2) tick(1, 0, 0);

    // Posedge rise: q=1 exactly 10 edges later
    tick(1, 1, 1);
    chk("t1_busy", 32'(bus0.busy), 1);
    chk("t1_pend_neg", 32'(bus0.pend_neg), 0);
    for (int i = 1; i <= 10; i++) begin
      tick(1, 1, 0);
      if (i == 9)  chk("t1_q_early", 32'(bus0.q), 0);
      if (i == 10) begin
        chk("t1_q", 32'(bus0.q), 1);
        chk("t1_busy_after", 32'(bus0.busy), 0);
      end
    end

    // Negedge fall: q=0 exactly 12 edges later
    tick(1, 0, 0);
    chk("t2_pend_neg", 32'(bus0.pend_neg), 1);
    for (int i = 1; i <= 12; i++) begin
      tick(1, 0, 1);
      if (i == 5)  chk("t2_pend_neg_mid", 32'(bus0.pend_neg), 1);
      if (i == 11) chk("t2_q_early", 32'(bus0.q), 1);
      if (i == 12) chk("t2_q", 32'(bus0.q), 0);
    end

    // Cancel: posedge data=1, negedge data=0 at +4
    tick(1, 1, 1);
    repeat (3) tick(1, 1, 0);
    tick(1, 0, 0);
    chk("t3_busy", 32'(bus0.busy), 0);
    chk("t3_q", 32'(bus0.q), 0);
    chk("t3_cancel_cnt", 32'(bus0.cancel_cnt), 1);
    repeat (8) tick(1, 0, 1);
    chk("t3_q_hold", 32'(bus0.q), 0);

    // Keep: posedge data=1, negedge data=1 at +3, q=1 at +10
    tick(1, 1, 1);
    repeat (2) tick(1, 1, 0);
    tick(1, 0, 1);
    for (int i = 4; i <= 10; i++) begin
      tick(1, 0, 0);
      if (i == 5)  chk("t4_pend_neg", 32'(bus0.pend_neg), 0);
      if (i == 9)  chk("t4_q_early", 32'(bus0.q), 0);
      if (i == 10) chk("t4_q", 32'(bus0.q), 1);
    end
    repeat (12) tick(1, 0, 0);
    chk("t4_q_hold", 32'(bus0.q), 1);

    // trig held high through reset: no event in ARM
    repeat (2) tick(0, 1, 1);
    tick(1, 1, 1);
    repeat (3) tick(1, 1, 1);
    chk("t5_busy", 32'(bus0.busy), 0);
    chk("t5_q", 32'(bus0.q), 0);
    // Raise q, start a fall, reset mid-countdown
    tick(1, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      tick(1, 0, 0);
      if (i == 20) chk("t5_q_rise", 32'(bus0.q), 1);
    end
    tick(1, 1, 0);
    repeat (2) tick(1, 1, 0);
    chk("t5_busy_mid", 32'(bus0.busy), 1);
    tick(0, 1, 0);
    chk("t5_rst_q", 32'(bus0.q), 0);
    chk("t5_rst_busy", 32'(bus0.busy), 0);
    tick(1, 1, 0);

    // NEG_RISE=0 behaves as 1
    tick(1, 0, 1);
    chk("t6_z_busy", 32'(bus1.busy), 1);
    chk("t6_z_q_early", 32'(bus1.q), 0);
    tick(1, 0, 0);
    chk("t6_z_q", 32'(bus1.q), 1);
    repeat (25) tick(1, 0, 0);

    // 300 cancels saturate at 255
    for (int i = 0; i < 300; i++) begin
      tick(1, 1, 0);
      tick(1, 0, 1);
    end
    chk("t6_sat", 32'(bus0.cancel_cnt), 255);
    chk("t6_z_sat", 32'(bus1.cancel_cnt), 255);

    // Random phase
    begin
      bit t, d, rn;
      t = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(3) == 0) t = ~t;
        d  = 1'($urandom_range(1));
        rn = ($urandom_range(199) != 0);
        tick(rn, t, d);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
